pipe_trace_buffer: RTL and testbench

Hardware retirement trace for the RV32I pipeline: records every write-back-stage retirement (pc, rd, write enable, data) into a parametrised circular buffer. A PC-match or external trigger freezes the capture window after a programmable post-trigger count. The captured window is then drained oldest-first over a valid/ready port. Sits beside the MEM/WB register and replaces per-cycle bench printing with on-chip capture usable in simulation and on FPGA.

---
 rtl/pipe_trace_buffer_pkg.sv | 49 ++++
 rtl/pipe_trace_buffer_if.sv | 37 +++
 rtl/pipe_trace_buffer_trace_ram.sv | 31 +++
 rtl/pipe_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_trace_buffer_pkg.sv
// Shared definitions for the RV32I retirement trace buffer.
//
// Contents:
//   trace_state_e  - capture FSM encoding (IDLE=0, ARMED=1, POST=2, FROZEN=3)
//   TS_W           - timestamp field width (32 when TRACE_TIMESTAMP_EN is defined, else 0)
//   entry_w()      - width of one trace entry
//   *_lsb()/regwr_bit() - field offsets inside an entry
//
// Entry layout, MSB to LSB: {pc, reg_wr, rd, data}[, timestamp]
//
// Optional feature macro: TRACE_TIMESTAMP_EN
package pipe_trace_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } trace_state_e;

`ifdef TRACE_TIMESTAMP_EN
    localparam int TS_W = 32;
`else
    localparam int TS_W = 0;
`endif

    localparam int TS_LSB = 0;

    function automatic int entry_w(input int xlen, input int reg_addr_w);
        return 2 * xlen + reg_addr_w + 1 + TS_W;
    endfunction

    function automatic int data_lsb();
        return TS_W;
    endfunction

    function automatic int rd_lsb(input int xlen);
        return TS_W + xlen;
    endfunction

    function automatic int regwr_bit(input int xlen, input int reg_addr_w);
        return TS_W + xlen + reg_addr_w;
    endfunction

    function automatic int pc_lsb(input int xlen, input int reg_addr_w);
        return TS_W + xlen + reg_addr_w + 1;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Retirement-in / drain-out bus of the trace buffer.
//
// Signals:
//   wb_valid, wb_reg_wr, wb_rd, wb_data, wb_pc - write-back retirement (pipeline -> buffer)
//   out_valid, out_data                        - drained entry (buffer -> consumer)
//   out_ready                                  - consumer accepts entry
// Modports:
//   master - pipeline/consumer side
//   slave  - trace buffer side
//
// ENTRY_W follows TRACE_TIMESTAMP_EN through pipe_trace_pkg::entry_w().
interface pipe_trace_buffer_if
    import pipe_trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ENTRY_W    = entry_w(XLEN, REG_ADDR_W)
);
    logic                  wb_valid;
    logic                  wb_reg_wr;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic [XLEN-1:0]       wb_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [ENTRY_W-1:0]    out_data;

    modport master (
        output wb_valid, wb_reg_wr, wb_rd, wb_data, wb_pc, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  wb_valid, wb_reg_wr, wb_rd, wb_data, wb_pc, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/pipe_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x WIDTH register array holding trace entries.
//
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write index
//   wdata - entry to store
//   raddr - read index
//   rdata - entry at raddr (asynchronous read, zero latency)
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 70,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; slots are only read after being written
    // (entries counts them), and an unreset array can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer: circular capture of write-back retirements with a
// PC-match / external trigger, a post-trigger window and an oldest-first drain.
//
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   enable            - capture qualifier (0: no write, state holds)
//   arm               - pulse: discard contents, restart capture
//   trig_en, trig_pc  - PC-match trigger enable and target
//   trig_ext          - external trigger pulse
//   bus (slave)       - retirement input and valid/ready drain output
//   entries           - number of valid entries held
//   state_o           - IDLE=0, ARMED=1, POST=2, FROZEN=3
//   triggered         - sticky trigger-seen flag, cleared by arm
//
// Optional feature macro: TRACE_TIMESTAMP_EN appends a free-running 32-bit
// cycle count as the entry LSBs.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 16,
    parameter int POST_TRIG  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       arm,
    input  logic                       trig_en,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       trig_ext,
    pipe_trace_buffer_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] entries,
    output logic [1:0]                 state_o,
    output logic                       triggered
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = entry_w(XLEN, REG_ADDR_W);

    trace_state_e       state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   post_cnt;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic               capture;
    logic               wr_en;
    logic               trig_hit;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_cnt <= '0;
        else      ts_cnt <= ts_cnt + 32'd1;
    end

    assign wr_entry = {bus.wb_pc, bus.wb_reg_wr, bus.wb_rd, bus.wb_data, ts_cnt};
`else
    assign wr_entry = {bus.wb_pc, bus.wb_reg_wr, bus.wb_rd, bus.wb_data};
`endif

    assign capture  = (state == ARMED || state == POST) && enable && bus.wb_valid;
    // arm wins over a capture in the same cycle.
    assign wr_en    = capture && !arm;
    assign trig_hit = (state == ARMED) &&
                      ((trig_en && enable && bus.wb_valid && bus.wb_pc == trig_pc) || trig_ext);

    // Oldest entry sits 'entries' slots behind the write pointer; when full the
    // low bits of entries are zero, so the oldest slot is wr_ptr itself.
    assign rd_ptr = wr_ptr - entries[PTR_W-1:0];

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            entries   <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
        end else if (arm) begin
            state     <= ARMED;
            wr_ptr    <= '0;
            entries   <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of wr_ptr/entries/post_cnt.
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (entries != CNT_W'(DEPTH)) entries <= entries + CNT_W'(1);
            end

            case (state)
                IDLE: ;
                ARMED: begin
                    if (trig_hit) begin
                        triggered <= 1'b1;
                        if (POST_TRIG == 0) begin
                            state <= FROZEN;
                        end else begin
                            state    <= POST;
                            post_cnt <= CNT_W'(POST_TRIG);
                        end
                    end
                end
                POST: begin
                    if (capture) begin
                        post_cnt <= post_cnt - CNT_W'(1);
                        if (post_cnt == CNT_W'(1)) state <= FROZEN;
                    end
                end
                FROZEN: begin
                    if (entries == '0) begin
                        state <= IDLE;
                    end else if (bus.out_ready) begin
                        entries <= entries - CNT_W'(1);
                        if (entries == CNT_W'(1)) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_o       = state;
    assign bus.out_valid = (state == FROZEN) && (entries != '0);
    // Gated so out_data reads zero whenever nothing is offered.
    assign bus.out_data  = bus.out_valid ? rd_entry : '0;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed self-checking bench for pipe_trace_buffer.
// Two instances share the stimulus: dut (POST_TRIG=8) and dut0 (POST_TRIG=0).
module tb_pipe_trace_buffer;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 2 * XLEN + RAW + 1 + 32;
`else
    localparam int EW = 2 * XLEN + RAW + 1;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable, arm, trig_en, trig_ext;
    logic [XLEN-1:0] trig_pc;
    logic            wb_valid, wb_reg_wr;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] wb_data, wb_pc;
    logic            rdy, rdy0;

    logic [4:0]      entries, entries0;
    logic [1:0]      state_o, state0;
    logic            triggered, triggered0;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_trace_buffer_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .ENTRY_W(EW)) bus  ();
    pipe_trace_buffer_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .ENTRY_W(EW)) bus0 ();

    assign bus.wb_valid   = wb_valid;
    assign bus.wb_reg_wr  = wb_reg_wr;
    assign bus.wb_rd      = wb_rd;
    assign bus.wb_data    = wb_data;
    assign bus.wb_pc      = wb_pc;
    assign bus.out_ready  = rdy;
    assign bus0.wb_valid  = wb_valid;
    assign bus0.wb_reg_wr = wb_reg_wr;
    assign bus0.wb_rd     = wb_rd;
    assign bus0.wb_data   = wb_data;
    assign bus0.wb_pc     = wb_pc;
    assign bus0.out_ready = rdy0;

    pipe_trace_buffer #(.XLEN(XLEN), .REG_ADDR_W(RAW), .DEPTH(16), .POST_TRIG(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .trig_ext(trig_ext), .bus(bus),
        .entries(entries), .state_o(state_o), .triggered(triggered)
    );

    pipe_trace_buffer #(.XLEN(XLEN), .REG_ADDR_W(RAW), .DEPTH(16), .POST_TRIG(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .arm(arm), .trig_en(trig_en),
        .trig_pc(trig_pc), .trig_ext(trig_ext), .bus(bus0),
        .entries(entries0), .state_o(state0), .triggered(triggered0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_pc(input logic [EW-1:0] d);
        return d[EW-1 -: 32];
    endfunction
    function automatic logic [4:0] f_rd(input logic [EW-1:0] d);
        return d[EW-34 -: 5];
    endfunction
    function automatic logic [31:0] f_data(input logic [EW-1:0] d);
        return d[EW-39 -: 32];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wb_valid = 1'b0;
        trig_ext = 1'b0;
        arm      = 1'b0;
    endtask

    task automatic do_arm();
        quiet();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // One retirement; rd and data are derived from pc so the drain can be checked.
    task automatic retire(input logic [31:0] pc, input logic ext);
        wb_valid  = 1'b1;
        wb_reg_wr = 1'b1;
        wb_rd     = pc[6:2];
        wb_data   = pc ^ 32'hA5A5_0000;
        wb_pc     = pc;
        trig_ext  = ext;
        tick();
    endtask

    initial begin
        enable = 1'b1; arm = 1'b0; trig_en = 1'b0; trig_pc = '0; trig_ext = 1'b0;
        wb_valid = 1'b0; wb_reg_wr = 1'b0; wb_rd = '0; wb_data = '0; wb_pc = '0;
        rdy = 1'b0; rdy0 = 1'b0;

        // ---- reset state ----
        tick(); tick();
        check("rst_state", state_o, 2'd0);
        check("rst_entries", entries, 5'd0);
        check("rst_trig", triggered, 1'b0);
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, '0);
        rst = 1'b1;
        tick();
        check("idle_hold", state_o, 2'd0);

        // ---- basic capture on dut0 (POST_TRIG=0) ----
        do_arm();
        check("armed", state0, 2'd1);
        for (int i = 0; i < 5; i++) retire(32'(4 * i), i == 4);
        quiet();
        check("b_state0", state0, 2'd3);
        check("b_entries0", entries0, 5'd5);
        check("b_trig0", triggered0, 1'b1);
        check("b_valid0", bus0.out_valid, 1'b1);
        check("b_state_post", state_o, 2'd2);
        check("b_entries_post", entries, 5'd5);
        rdy0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("b_pc", f_pc(bus0.out_data), 64'(4 * k));
            check("b_rd", f_rd(bus0.out_data), 64'(k));
            tick();
        end
        rdy0 = 1'b0;
        check("b_idle0", state0, 2'd0);
        check("b_empty0", entries0, 5'd0);
        check("b_nvalid0", bus0.out_valid, 1'b0);

        // ---- wrap with PC trigger ----
        do_arm();
        trig_en = 1'b1;
        trig_pc = 32'h40;
        for (int i = 0; i < 30; i++) retire(32'(4 * i), 1'b0);
        quiet();
        trig_en = 1'b0;
        check("w_state", state_o, 2'd3);
        check("w_entries", entries, 5'd16);
        check("w_trig", triggered, 1'b1);
        check("w_oldest", f_pc(bus.out_data), 64'h24);
        check("w_state0", state0, 2'd3);
        check("w_entries0", entries0, 5'd16);
        check("w_oldest0", f_pc(bus0.out_data), 64'h04);

        // ---- backpressure: out_ready 1,0,0,1 ----
        rdy = 1'b1; tick();
        check("bp_pop1", entries, 5'd15);
        check("bp_pc1", f_pc(bus.out_data), 64'h28);
        rdy = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick();
            check("bp_hold_n", entries, 5'd15);
            check("bp_hold_pc", f_pc(bus.out_data), 64'h28);
            check("bp_hold_data", f_data(bus.out_data), 64'hA5A5_0028);
            check("bp_hold_v", bus.out_valid, 1'b1);
        end
        rdy = 1'b1; tick();
        check("bp_pop2", entries, 5'd14);
        for (int k = 2; k < 16; k++) begin
            check("w_drain_pc", f_pc(bus.out_data), 64'(32'h24 + 4 * k));
            tick();
        end
        rdy = 1'b0;
        check("w_idle", state_o, 2'd0);
        check("w_empty", entries, 5'd0);

        // ---- trigger before any capture ----
        do_arm();
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        check("e_frozen0", state0, 2'd3);
        check("e_entries0", entries0, 5'd0);
        check("e_nvalid0", bus0.out_valid, 1'b0);
        check("e_post", state_o, 2'd2);
        tick();
        check("e_idle0", state0, 2'd0);
        check("e_sticky0", triggered0, 1'b1);

        // ---- enable gating ----
        do_arm();
        trig_en = 1'b1;
        trig_pc = 32'h104;
        for (int c = 0; c < 6; c++) begin
            enable = !(c == 1 || c == 2);
            retire(32'(32'h100 + 4 * c), 1'b0);
        end
        enable = 1'b1;
        quiet();
        trig_en = 1'b0;
        check("g_entries", entries, 5'd4);
        check("g_state", state_o, 2'd1);
        check("g_notrig", triggered, 1'b0);
        trig_ext = 1'b1; tick(); trig_ext = 1'b0;
        check("g_post", state_o, 2'd2);
        check("g_trig", triggered, 1'b1);

        // ---- re-arm mid-drain ----
        do_arm();
        for (int i = 0; i < 10; i++) retire(32'(32'h200 + 4 * i), i == 1);
        quiet();
        check("r_state", state_o, 2'd3);
        check("r_entries", entries, 5'd10);
        rdy = 1'b1; tick(); tick();
        rdy = 1'b0;
        check("r_entries8", entries, 5'd8);
        check("r_pc", f_pc(bus.out_data), 64'h208);
        rdy = 1'b1; arm = 1'b1; tick();
        rdy = 1'b0;
        check("r_cleared", entries, 5'd0);
        check("r_ntrig", triggered, 1'b0);
        check("r_armed", state_o, 2'd1);
        check("r_nvalid", bus.out_valid, 1'b0);
        // arm again while ARMED, alongside a retirement and a trigger
        wb_valid = 1'b1; wb_reg_wr = 1'b1; wb_pc = 32'h998; wb_rd = 5'd3; wb_data = 32'h1;
        trig_ext = 1'b1; arm = 1'b1; tick();
        quiet();
        check("r2_entries", entries, 5'd0);
        check("r2_ntrig", triggered, 1'b0);
        check("r2_armed", state_o, 2'd1);
        for (int i = 0; i < 9; i++) retire(32'(32'h300 + 4 * i), i == 0);
        quiet();
        check("r_refrozen", state_o, 2'd3);
        check("r_ref_n", entries, 5'd9);
        check("r_first", f_pc(bus.out_data), 64'h300);

        // ---- async reset during POST ----
        do_arm();
        retire(32'h400, 1'b1);
        quiet();
        check("a_post", state_o, 2'd2);
        check("a_n", entries, 5'd1);
        #2 rst = 1'b0;
        #1;
        check("a_state", state_o, 2'd0);
        check("a_entries", entries, 5'd0);
        check("a_trig", triggered, 1'b0);
        check("a_valid", bus.out_valid, 1'b0);
        check("a_data", bus.out_data, '0);
        @(negedge clk) rst = 1'b1;
        tick();
        check("a_after", state_o, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
